// File: rtl/adder_serial_nbit.sv
// Multi-cycle ripple adder: sums two NUM_BITS operands CHUNK_BITS per clock behind a start/busy/done handshake.
// Optional build macro ADDER_SAT_EN saturates sum to all ones when the final carry is set.
module adder_serial_nbit #(
  parameter int NUM_BITS   = 16,
  parameter int CHUNK_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow
);

  localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [NUM_BITS-1:0] a_reg, a_next;
  logic [NUM_BITS-1:0] b_reg, b_next;
  logic                carry_reg, carry_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [NUM_BITS-1:0] partial_reg, partial_next;
  logic [NUM_BITS-1:0] sum_reg, sum_next;
  logic                overflow_reg, overflow_next;

  logic [CHUNK_BITS-1:0] a_chunk [NUM_CHUNKS];
  logic [CHUNK_BITS-1:0] b_chunk [NUM_CHUNKS];
  logic [CHUNK_BITS:0]   chunk_sum;
  logic [NUM_BITS-1:0]   partial_upd;

  // Slice operands into chunks and merge the current chunk result into the partial sum.
  for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
    assign a_chunk[gi] = a_reg[gi*CHUNK_BITS +: CHUNK_BITS];
    assign b_chunk[gi] = b_reg[gi*CHUNK_BITS +: CHUNK_BITS];
    assign partial_upd[gi*CHUNK_BITS +: CHUNK_BITS] =
      (cnt_reg == CNT_W'(gi)) ? chunk_sum[CHUNK_BITS-1:0]
                              : partial_reg[gi*CHUNK_BITS +: CHUNK_BITS];
  end

  assign chunk_sum = {1'b0, a_chunk[cnt_reg]} + {1'b0, b_chunk[cnt_reg]}
                   + {{CHUNK_BITS{1'b0}}, carry_reg};

  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    carry_next    = carry_reg;
    cnt_next      = cnt_reg;
    partial_next  = partial_reg;
    sum_next      = sum_reg;
    overflow_next = overflow_reg;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_reg)
      ADD: begin
        busy         = 1'b1;
        partial_next = partial_upd;
        carry_next   = chunk_sum[CHUNK_BITS];
        cnt_next     = cnt_reg + 1'b1;
        if (cnt_reg == LAST_CHUNK) begin
          state_next    = DONE;
          cnt_next      = '0;
          overflow_next = chunk_sum[CHUNK_BITS];
`ifdef ADDER_SAT_EN
          sum_next      = chunk_sum[CHUNK_BITS] ? {NUM_BITS{1'b1}} : partial_upd;
`else
          sum_next      = partial_upd;
`endif
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A start is honoured from both IDLE and DONE so back-to-back operations lose no cycle.
    if ((state_reg == IDLE || state_reg == DONE) && start) begin
      state_next   = ADD;
      a_next       = a;
      b_next       = b;
      carry_next   = carry_in;
      cnt_next     = '0;
      partial_next = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      carry_reg    <= 1'b0;
      cnt_reg      <= '0;
      partial_reg  <= '0;
      sum_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      carry_reg    <= carry_next;
      cnt_reg      <= cnt_next;
      partial_reg  <= partial_next;
      sum_reg      <= sum_next;
      overflow_reg <= overflow_next;
    end
  end

  assign sum      = sum_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_adder_serial_nbit.sv
// Directed bench for adder_serial_nbit at the default 16-bit / 4-bit-chunk configuration.
// Expected results are hand-computed; the saturating build (ADDER_SAT_EN) changes only overflowed sums.
module tb_adder_serial_nbit;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        overflow;

  int checks;
  int errors;

  adder_serial_nbit #(
    .NUM_BITS  (16),
    .CHUNK_BITS(4)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .carry_in(carry_in),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ADDER_SAT_EN
  localparam logic [15:0] OVF_FFFF_0001 = 16'hFFFF;
  localparam logic [15:0] OVF_8000_8000 = 16'hFFFF;
`else
  localparam logic [15:0] OVF_FFFF_0001 = 16'h0000;
  localparam logic [15:0] OVF_8000_8000 = 16'h0001;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // Entered just after a rising edge with the DUT in IDLE or DONE; leaves just after the done edge.
  task automatic run_add(input string tag, input logic [15:0] ta, input logic [15:0] tb_op,
                         input logic tcin, input logic [15:0] exp_sum, input logic exp_ov,
                         input logic [15:0] prev_sum, input bit wiggle);
    a = ta; b = tb_op; carry_in = tcin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, busy, 1'b1);
      check({tag, "_nodone"}, done, 1'b0);
      check({tag, "_hold"}, sum, prev_sum);
      if (wiggle) begin
        a = 16'($urandom); b = 16'($urandom); carry_in = 1'($urandom); start = ~start;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_ovf"}, overflow, exp_ov);
  endtask

  task automatic idle_cycle(input string tag, input logic [15:0] exp_sum);
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, done, 1'b0);
    check({tag, "_sum_kept"}, sum, exp_sum);
  endtask

  initial begin
    int done_seen;
    checks = 0; errors = 0;
    n_rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;

    #3;
    check("rst_sum", sum, 16'h0000);
    check("rst_ovf", overflow, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(posedge clk); @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;

    run_add("basic", 16'h1234, 16'h0F0F, 1'b0, 16'h2143, 1'b0, 16'h0000, 1'b0);
    idle_cycle("basic", 16'h2143);
    run_add("carry", 16'h000F, 16'h0000, 1'b1, 16'h0010, 1'b0, 16'h2143, 1'b0);
    idle_cycle("carry", 16'h0010);
    run_add("ovf", 16'hFFFF, 16'h0001, 1'b0, OVF_FFFF_0001, 1'b1, 16'h0010, 1'b0);
    // start issued during the DONE cycle of the previous operation
    run_add("b2b", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, OVF_FFFF_0001, 1'b0);
    idle_cycle("b2b", 16'h0002);
    run_add("wiggle", 16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 16'h0002, 1'b1);
    idle_cycle("wiggle", 16'h3334);
    run_add("allones", 16'hABCD, 16'h5432, 1'b0, 16'hFFFF, 1'b0, 16'h3334, 1'b0);
    idle_cycle("allones", 16'hFFFF);
    run_add("msbovf", 16'h8000, 16'h8000, 1'b1, OVF_8000_8000, 1'b1, 16'hFFFF, 1'b0);
    idle_cycle("msbovf", OVF_8000_8000);

    // Reset in the middle of an addition, asserted away from any clock edge.
    a = 16'h1234; b = 16'h0F0F; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("mid_busy_before", busy, 1'b1);
    n_rst = 1'b0;
    #1;
    check("mid_rst_sum", sum, 16'h0000);
    check("mid_rst_ovf", overflow, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    @(posedge clk); @(negedge clk);
    n_rst = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    check("mid_no_done_after", done_seen, 0);

    run_add("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 16'h0000, 1'b0);
    idle_cycle("post_rst", 16'h1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
